// File: rtl/seven_seg_capture.sv
// +----------------------------------------------------------------------------+
// | seven_seg_capture                                                          |
// | Recovers a multiplexed 7-segment frame and presents it as a binary value.  |
// | Optional build macro: SEVEN_SEG_CAPTURE_HEX_EN (hex digits, base-16 value).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seven_seg_capture #(
   parameter int W_DIGIT       = 8,
   parameter int N_DIGITS      = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int W_VALUE       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         abcdefgh,
   input  logic [W_DIGIT-1:0] digit,
   output logic [W_VALUE-1:0] value,
   output logic               value_valid,
   input  logic               value_ready,
   output logic               frame_error
);

   localparam int c_w_cnt = $clog2(STABLE_CYCLES + 1);
   localparam int c_w_idx = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
   localparam logic [W_VALUE-1:0] c_radix = W_VALUE'(16);
`else
   localparam logic [W_VALUE-1:0] c_radix = W_VALUE'(10);
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   logic [7:0]         r_seg, r_seg_prev;
   logic [W_DIGIT-1:0] r_dig, r_dig_prev;
   logic [c_w_cnt-1:0] r_cnt;
   logic [3:0]         r_slot [N_DIGITS];
   logic [3:0]         r_snap [N_DIGITS];
   logic [N_DIGITS-1:0] r_mask, r_bad;
   logic               r_snap_bad;
   logic [W_VALUE-1:0] r_acc, r_value;
   logic [c_w_idx-1:0] r_idx;
   logic               r_valid, r_frame_error;
   state_t             r_state;

   logic               w_same, w_onehot, w_in_range, w_accept;
   logic [c_w_idx-1:0] w_sel_idx;
   logic [4:0]         w_dec;
   logic [W_VALUE-1:0] w_acc_next;

   // Returns {unknown, digit}; the decimal point (h) never takes part.
   function automatic logic [4:0] f_decode(input logic [6:0] seg);
      logic [4:0] d;
      case ({seg, 1'b0})
         8'hFC:   d = 5'd0;
         8'h60:   d = 5'd1;
         8'hDA:   d = 5'd2;
         8'hF2:   d = 5'd3;
         8'h66:   d = 5'd4;
         8'hB6:   d = 5'd5;
         8'hBE:   d = 5'd6;
         8'hE0:   d = 5'd7;
         8'hFE:   d = 5'd8;
         8'hF6:   d = 5'd9;
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
         8'hEE:   d = 5'd10;
         8'h3E:   d = 5'd11;
         8'h9C:   d = 5'd12;
         8'h7A:   d = 5'd13;
         8'h9E:   d = 5'd14;
         8'h8E:   d = 5'd15;
`endif
         default: d = 5'h10;
      endcase
      return d;
   endfunction

   assign w_same     = (r_seg == r_seg_prev) && (r_dig == r_dig_prev);
   assign w_onehot   = (r_dig != '0) && ((r_dig & (r_dig - W_DIGIT'(1))) == '0);
   assign w_in_range = |r_dig[N_DIGITS-1:0];
   // Fires only on the transition into STABLE_CYCLES-1; saturation blocks repeats.
   assign w_accept   = w_same && (r_cnt == c_w_cnt'(STABLE_CYCLES - 2)) && w_onehot && w_in_range;
   assign w_dec      = f_decode(r_seg[7:1]);
   assign w_acc_next = r_acc * c_radix + W_VALUE'(r_snap[r_idx]);

   always_comb begin
      w_sel_idx = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (r_dig[i]) begin
            w_sel_idx = c_w_idx'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg      <= '0;
         r_dig      <= '0;
         r_seg_prev <= '0;
         r_dig_prev <= '0;
         r_cnt      <= '0;
      end else begin
         r_seg      <= abcdefgh;
         r_dig      <= digit;
         r_seg_prev <= r_seg;
         r_dig_prev <= r_dig;
         if (!w_same) begin
            r_cnt <= '0;
         end else if (r_cnt != c_w_cnt'(STABLE_CYCLES)) begin
            r_cnt <= r_cnt + c_w_cnt'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            r_slot[i] <= '0;
            r_snap[i] <= '0;
         end
         r_mask        <= '0;
         r_bad         <= '0;
         r_snap_bad    <= 1'b0;
         r_acc         <= '0;
         r_idx         <= '0;
         r_value       <= '0;
         r_valid       <= 1'b0;
         r_frame_error <= 1'b0;
         r_state       <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (&r_mask) begin
                  for (int i = 0; i < N_DIGITS; i++) begin
                     r_snap[i] <= r_slot[i];
                  end
                  r_snap_bad <= |r_bad;
                  r_mask     <= '0;
                  r_bad      <= '0;
                  r_acc      <= '0;
                  r_idx      <= c_w_idx'(N_DIGITS - 1);
                  r_state    <= S_CONV;
               end
            end
            S_CONV: begin
               r_acc <= w_acc_next;
               if (r_idx == '0) begin
                  r_value       <= w_acc_next;
                  r_frame_error <= r_snap_bad;
                  r_valid       <= 1'b1;
                  r_state       <= S_HOLD;
               end else begin
                  r_idx <= r_idx - c_w_idx'(1);
               end
            end
            S_HOLD: begin
               if (r_valid && value_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Placed after the snapshot clear so a same-cycle digit lands in the new frame.
         if (w_accept) begin
            r_slot[w_sel_idx] <= w_dec[3:0];
            r_bad[w_sel_idx]  <= w_dec[4];
            r_mask[w_sel_idx] <= 1'b1;
         end
      end
   end

   assign value       = r_value;
   assign value_valid = r_valid;
   assign frame_error = r_frame_error;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
// +----------------------------------------------------------------------------+
// | tb_seven_seg_capture                                                       |
// | Directed and randomized frames against a digit-table reference model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seven_seg_capture;

`ifdef SEVEN_SEG_CAPTURE_HEX_EN
   localparam int NSYM  = 16;
   localparam int RADIX = 16;
`else
   localparam int NSYM  = 10;
   localparam int RADIX = 10;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  abcdefgh = 8'h00;
   logic [7:0]  digit = 8'h00;
   logic        value_ready = 1'b0;
   logic [15:0] value;
   logic        value_valid;
   logic        frame_error;

   int errors = 0;
   int checks = 0;
   int rd = 0;
   int vcount = 0;
   logic [16:0] got [$];

   logic [7:0] seg_tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

   seven_seg_capture #(
      .W_DIGIT(8), .N_DIGITS(4), .STABLE_CYCLES(4), .W_VALUE(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .abcdefgh(abcdefgh), .digit(digit),
      .value(value), .value_valid(value_valid), .value_ready(value_ready),
      .frame_error(frame_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (value_valid) vcount++;
      if (rst_n && value_valid && value_ready) got.push_back({frame_error, value});
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] sel, input logic [7:0] pat, input int n);
      digit    = sel;
      abcdefgh = pat;
      repeat (n) tick();
   endtask

   task automatic blank(input int n);
      drive(8'h00, 8'h00, n);
   endtask

   task automatic send_frame(input logic [7:0] p [4], input int ord [4], input int hold);
      for (int i = 0; i < 4; i++) drive(8'(1 << ord[i]), p[ord[i]], hold);
      blank(2);
   endtask

   task automatic wait_frame(input string tag, input logic [15:0] ev, input logic ef);
      logic [16:0] e;
      int k;
      k = 0;
      while (got.size() <= rd && k < 60) begin
         tick();
         k++;
      end
      check({tag, ".arrived"}, 32'(got.size() > rd), 32'd1);
      if (got.size() > rd) begin
         e = got[rd];
         rd++;
         check({tag, ".value"}, 32'(e[15:0]), 32'(ev));
         check({tag, ".frame_error"}, 32'(e[16]), 32'(ef));
      end
   endtask

   // Reference: each digit's weight is RADIX^position; unknown patterns count as 0 and flag an error.
   function automatic void model(input logic [7:0] p [4], output int val, output logic err);
      int d;
      val = 0;
      err = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d = -1;
         for (int k = 0; k < NSYM; k++) begin
            if (p[i][7:1] == seg_tbl[k][7:1]) d = k;
         end
         if (d < 0) err = 1'b1;
         else val += d * (RADIX ** i);
      end
   endfunction

   initial begin
      logic [7:0] p [4];
      int ord [4];
      int ev, v0, k, j, tmp;
      logic ee;

      ord = '{0, 1, 2, 3};
      value_ready = 1'b1;
      repeat (3) tick();
      check("reset.value", 32'(value), 32'd0);
      check("reset.value_valid", 32'(value_valid), 32'd0);
      check("reset.frame_error", 32'(frame_error), 32'd0);
      rst_n = 1'b1;
      tick();

      p = '{seg_tbl[4], seg_tbl[3], seg_tbl[2], seg_tbl[1]};
      v0 = vcount;
      send_frame(p, ord, 16);
      wait_frame("dec1234", 16'd1234, 1'b0);
      repeat (4) tick();
      check("dec1234.valid_cycles", 32'(vcount - v0), 32'd1);

      drive(8'h01, seg_tbl[5], 8);
      drive(8'h04, seg_tbl[5], 8);
      drive(8'h08, seg_tbl[5], 8);
      for (int t = 0; t < 6; t++) begin
         drive(8'h02, 8'h60, 2);
         drive(8'h02, 8'hDA, 2);
      end
      blank(10);
      check("glitch.no_frame", 32'(got.size()), 32'(rd));
      check("glitch.no_valid", 32'(value_valid), 32'd0);
      drive(8'h02, 8'hDA, 3);
      blank(12);
      check("stable3.no_frame", 32'(got.size()), 32'(rd));
      drive(8'h02, 8'hDA, 4);
      blank(2);
      wait_frame("stable4", 16'd5525, 1'b0);

      p = '{seg_tbl[5], seg_tbl[5], 8'h02, seg_tbl[5]};
      send_frame(p, ord, 8);
      wait_frame("badpat", 16'd5055, 1'b1);

      drive(8'h01, seg_tbl[1], 8);
      drive(8'h02, seg_tbl[2], 8);
      drive(8'h04, seg_tbl[3], 8);
      drive(8'h03, seg_tbl[9], 16);
      drive(8'h10, seg_tbl[9], 16);
      blank(10);
      check("illegal.no_frame", 32'(got.size()), 32'(rd));
      check("illegal.no_valid", 32'(value_valid), 32'd0);
      drive(8'h08, seg_tbl[4], 8);
      blank(2);
      wait_frame("illegal_sel", 16'd4321, 1'b0);

      value_ready = 1'b0;
      p = '{seg_tbl[2], seg_tbl[4], seg_tbl[0], seg_tbl[0]};
      send_frame(p, ord, 8);
      p = '{seg_tbl[9], seg_tbl[9], seg_tbl[9], seg_tbl[9]};
      send_frame(p, ord, 8);
      blank(10);
      check("bp.held_value", 32'(value), 32'd42);
      check("bp.held_valid", 32'(value_valid), 32'd1);
      check("bp.no_handshake", 32'(got.size()), 32'(rd));
      value_ready = 1'b1;
      tick();
      value_ready = 1'b0;
      wait_frame("bp_first", 16'd42, 1'b0);
      k = 0;
      while (!value_valid && k < 20) begin
         tick();
         k++;
      end
      check("bp.second_valid", 32'(value_valid), 32'd1);
      check("bp.second_value", 32'(value), 32'd9999);
      value_ready = 1'b1;
      wait_frame("bp_second", 16'd9999, 1'b0);

      drive(8'h01, seg_tbl[4], 16);
      drive(8'h02, seg_tbl[5], 16);
      drive(8'h04, seg_tbl[6], 16);
      digit    = 8'h08;
      abcdefgh = seg_tbl[7];
      repeat (7) tick();
      rst_n = 1'b0;
      #1;
      check("midconv_rst.value", 32'(value), 32'd0);
      check("midconv_rst.value_valid", 32'(value_valid), 32'd0);
      check("midconv_rst.frame_error", 32'(frame_error), 32'd0);
      digit    = 8'h00;
      abcdefgh = 8'h00;
      tick();
      tick();
      rst_n = 1'b1;
      v0 = vcount;
      blank(25);
      check("post_rst.no_valid", 32'(vcount - v0), 32'd0);
      check("post_rst.no_frame", 32'(got.size()), 32'(rd));

      p = '{seg_tbl[14], seg_tbl[14], seg_tbl[15], seg_tbl[15]};
      send_frame(p, ord, 8);
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
      wait_frame("hex_FFEE", 16'hFFEE, 1'b0);
`else
      wait_frame("hex_as_bad", 16'h0000, 1'b1);
`endif

      for (int f = 0; f < 12; f++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 7) == 0) p[i] = 8'($urandom);
            else p[i] = seg_tbl[$urandom_range(0, NSYM - 1)] | 8'($urandom_range(0, 1));
         end
         ord = '{0, 1, 2, 3};
         for (int i = 3; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = ord[i];
            ord[i] = ord[j];
            ord[j] = tmp;
         end
         model(p, ev, ee);
         v0 = vcount;
         send_frame(p, ord, $urandom_range(4, 9));
         wait_frame($sformatf("rand%0d", f), 16'(ev), ee);
         tick();
         check($sformatf("rand%0d.valid_cycles", f), 32'(vcount - v0), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receive-side counterpart of the board's multiplexed 7-segment display driver.
- Samples the time-multiplexed segment bus (abcdefgh) and digit-select bus (digit), decodes each stable segment pattern back to a digit, and assembles one full frame.
- Converts the frame from BCD to binary and presents it on a valid/ready output.
- Used in loopback self-test and to read a score display driven by another board through gpio.

Parameters:
w_digit, 8, width of the digit-select bus
n_digits, 4, number of low digits captured; digit[0] is the least significant digit
stable_cycles, 4, consecutive identical samples required before a digit is accepted (≥2)
w_value, 16, output value width; must hold 10^n_digits − 1

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
abcdefgh  input  8  segments, active-high; bit7=a … bit1=g, bit0=h (decimal point)
digit  input  w_digit  digit select, active-high one-hot
value  output  w_value  decoded binary value
value_valid  output  1  value holds a new frame
value_ready  input  1  consumer accepts value
frame_error  output  1  frame held an undecodable pattern; qualified by value_valid

Behaviour:
- Reset values: value=0, value_valid=0, frame_error=0. All internal state clears: sample register, stability counter, slots, capture mask, bad mask, FSM=IDLE.
- Input stage: {abcdefgh,digit} is registered once per clk.
- Stability counter:
  - Clears when the registered sample differs from the previous one; otherwise increments, saturating at stable_cycles.
  - A digit is accepted once, on the cycle the counter reaches stable_cycles−1. This means stable_cycles identical registered samples. Re-acceptance needs a sample change.
- Acceptance filter:
  - Accepted only if digit is exactly one-hot with index i < n_digits.
  - digit=0, multi-hot, or i ≥ n_digits → ignored, no state change.
- Decode compares bits 7:1 only; h is ignored.
  - Patterns: 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6 (h=0 form).
  - On acceptance: slot[i] ← decoded digit, mask[i] ← 1.
  - Unknown pattern: slot[i] ← 0, bad[i] ← 1, mask[i] ← 1.
  - Re-accepting a digit already in the mask overwrites its slot and bad bit.
- FSM:
  - IDLE: when mask is all-ones → snapshot slots and bad into the converter, clear mask and bad, acc ← 0, idx ← n_digits−1, go to CONV.
  - CONV: acc ← acc*10 + snap[idx] each cycle, idx decrements. After idx=0 → value ← acc, frame_error ← |snap_bad, value_valid ← 1, go to HOLD.
  - HOLD: value and frame_error are stable. When value_valid && value_ready → value_valid ← 0, go to IDLE.
- Timing: value_valid rises n_digits+1 cycles after the mask becomes full (1 snapshot cycle + n_digits conversion cycles).
- Capture runs in every FSM state.
  - A frame completing during CONV/HOLD waits in the mask. IDLE takes it on the cycle after the handshake.
  - Zero-bubble back-to-back is not required.
- Simultaneous events: an acceptance on the same cycle as the snapshot lands in the cleared mask, so no digit is lost.
- Arithmetic: acc is w_value bits with no overflow check. Legal inputs cannot overflow given the parameter constraint.
- Reset mid-operation (any state, including CONV/HOLD): everything returns to reset values immediately. The partial frame is discarded.

Optional Feature:
- Macro: SEVEN_SEG_CAPTURE_HEX_EN.
- Defined:
  - Decode additionally accepts A=EE b=3E C=9C d=7A E=9E F=8E as 10–15.
  - CONV uses acc ← acc*16 + snap[idx].
  - w_value must be ≥ 4*n_digits.
- Undefined:
  - Those six patterns are unknown (set bad).
  - Conversion is decimal.

Test Plan:
- Decimal frame: drive 1234 multiplexed, each digit held 16 cycles, digits in order 0..3, value_ready=1 → value=1234 (0x04D2), frame_error=0, value_valid high for 1 cycle.
- Glitch rejection: stable_cycles=4, digit[1] pattern toggles 60/DA every 2 cycles → mask bit 1 never set, value_valid stays 0. Then hold DA 4 samples → accepted as 2.
- Bad pattern: digit[2] carries 0x02, others decode to 5 → value=5055, frame_error=1.
- Illegal select: digit=8'b0000_0011 and digit=8'b0001_0000 driven with valid patterns → ignored, no frame forms.
- Backpressure: value_ready=0, frames 0042 then 9999 → value=42 held with valid high. Raise ready for 1 cycle → next frame gives value=9999.
- Reset mid-CONV: assert rst_n=0 two cycles after the mask fills → value=0, value_valid=0 at once. No output after release without a fresh frame.
- HEX build (SEVEN_SEG_CAPTURE_HEX_EN): frame digits 3..0 = F,F,E,E → value=0xFFEE, frame_error=0.
